// File: rtl/pong_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl_if
//   Signal bundle between the pong game-flow controller and its surroundings
//   (frame timing, push buttons, ball position block, image block).
//
//   master modport : environment side; drives frame_tick/start/pause/posx and
//                    receives the controller outputs.
//   slave modport  : controller side (pong_game_ctrl).
//
//   frame_tick   one-cycle pulse per frame
//   start        raw push button, asynchronous to clk
//   pause        level, freezes play while high
//   posx[9:0]    current ball x position
//   ball_run     ball motion enable for the position block
//   ball_reset   one-cycle pulse, re-centre the ball
//   serve_dir    0 = serve toward left, 1 = serve toward right
//   score_l/r    player scores
//   game_state   IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
//   winner_valid high only in GAMEOVER
//   winner       0 = left won, 1 = right won
// -----------------------------------------------------------------------------
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic [9:0] posx;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] game_state;
    logic       winner_valid;
    logic       winner;

    modport master (
        output frame_tick, start, pause, posx,
        input  ball_run, ball_reset, serve_dir, score_l, score_r,
               game_state, winner_valid, winner
    );

    modport slave (
        input  frame_tick, start, pause, posx,
        output ball_run, ball_reset, serve_dir, score_l, score_r,
               game_state, winner_valid, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game-flow sequencer for the VGA pong design. Samples the ball position
//   once per frame, decides when the ball moves, when it is re-centred and
//   which side serves, keeps both scores and declares the winner.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high; clears all state
//     bus    pong_game_ctrl_if.slave (inputs frame_tick/start/pause/posx,
//            outputs ball_run/ball_reset/serve_dir/scores/state/winner)
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter logic [9:0] GOAL_L       = 10'd8,
    parameter logic [9:0] GOAL_R       = 10'd624,
    parameter logic [3:0] MAX_SCORE    = 4'd9,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] POINT_FRAMES = 8'd30
) (
    input  logic            clk,
    input  logic            reset,
    pong_game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_run_q, ball_run_d;
    logic       ball_reset_q, ball_reset_d;
    logic       start_s1_q, start_s1_d;
    logic       start_s2_q, start_s2_d;
    logic       start_prev_q, start_prev_d;
    logic [1:0] settle_q, settle_d;
    logic       start_evt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == MAX_SCORE) ? v : v + 4'd1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_dir_q  <= 1'b1;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b1;
            settle_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_dir_q  <= serve_dir_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_prev_q <= start_prev_d;
            settle_q     <= settle_d;
        end
    end

    // Start button: 2-flop synchroniser plus rising-edge detector. The
    // synchroniser is cleared by reset, so its output only reflects the real
    // button two edges later. Until then the edge detector's history is held
    // at 1, which keeps a button held through reset release from looking like
    // a fresh press; it must be released and pressed again.
    always_comb begin
        start_s1_d   = bus.start;
        start_s2_d   = start_s1_q;
        settle_d     = {settle_q[0], 1'b1};
        start_prev_d = settle_q[1] ? start_s2_q : 1'b1;
        start_evt    = start_s2_q & ~start_prev_q;
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        frame_cnt_d = bus.frame_tick ? frame_cnt_q + 8'd1 : frame_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_evt) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b1;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick && frame_cnt_q == SERVE_FRAMES - 8'd1)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Goals are judged only on unpaused frame ticks; GOAL_L < GOAL_R
                // makes the two branches mutually exclusive.
                if (bus.frame_tick && !bus.pause) begin
                    if (bus.posx <= GOAL_L) begin
                        score_r_d   = sat_inc(score_r_q);
                        serve_dir_d = 1'b0;
                        state_d     = ST_POINT;
                    end else if (bus.posx >= GOAL_R) begin
                        score_l_d   = sat_inc(score_l_q);
                        serve_dir_d = 1'b1;
                        state_d     = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (bus.frame_tick && frame_cnt_q == POINT_FRAMES - 8'd1) begin
                    if (score_l_q == MAX_SCORE || score_r_q == MAX_SCORE)
                        state_d = ST_GAMEOVER;
                    else
                        state_d = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any state entry restarts the frame count; a tick on the entry edge
        // is therefore not counted.
        if (state_d != state_q)
            frame_cnt_d = '0;

        ball_run_d   = (state_d == ST_PLAY) && !bus.pause;
        ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    end

    assign bus.game_state   = state_q;
    assign bus.score_l      = score_l_q;
    assign bus.score_r      = score_r_q;
    assign bus.serve_dir    = serve_dir_q;
    assign bus.ball_run     = ball_run_q;
    assign bus.ball_reset   = ball_reset_q;
    assign bus.winner_valid = (state_q == ST_GAMEOVER);
    assign bus.winner       = (state_q == ST_GAMEOVER) && (score_r_q == MAX_SCORE);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed bench for pong_game_ctrl. Stimulus pushes the expected output
//   snapshot into a queue just before the stimulus that should cause it; a
//   monitor samples the outputs on every falling edge and, whenever any output
//   changes, pops the next expectation and compares. A change with nothing
//   expected is an error, so early or spurious transitions are caught too.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SERVE    = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_POINT    = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;
    localparam int SERVE_N = 60;
    localparam int POINT_N = 30;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       run;
        logic       brst;
        logic       dir;
        logic       wv;
        logic       win;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    snap_t expq[$];
    int    exp_l, exp_r;
    bit    exp_dir;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d l=%0d r=%0d run=%0b brst=%0b dir=%0b wv=%0b win=%0b",
                         s.st, s.sl, s.sr, s.run, s.brst, s.dir, s.wv, s.win);
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input bit run, input bit brst,
                                 input bit wv, input bit win);
        snap_t s;
        s.st   = st;
        s.sl   = exp_l[3:0];
        s.sr   = exp_r[3:0];
        s.run  = run;
        s.brst = brst;
        s.dir  = exp_dir;
        s.wv   = wv;
        s.win  = win;
        return s;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Monitor: any change in the output tuple is one DUT "presentation".
    initial begin
        snap_t cur, last, want;
        bit have_last;
        have_last = 1'b0;
        forever begin
            @(negedge clk);
            cur = '{bus.game_state, bus.score_l, bus.score_r, bus.ball_run,
                    bus.ball_reset, bus.serve_dir, bus.winner_valid, bus.winner};
            if (!have_last || cur != last) begin
                have_last = 1'b1;
                last      = cur;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got {%s} expected no change", fmt(cur));
                end else begin
                    want = expq.pop_front();
                    if (cur != want) begin
                        errors++;
                        $display("FAIL output_event got {%s} expected {%s}", fmt(cur), fmt(want));
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cycles(1);
            bus.frame_tick = 1'b0;
            cycles(3);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycles(1);
            if (bus.game_state == s) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s state=%0d expected=%0d within %0d clk", name, bus.game_state, s, budget);
        end
    endtask

    task automatic push_serve_entry();
        expq.push_back(mk(S_SERVE, 1'b0, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(S_SERVE, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // From SERVE entry: 59 quiet ticks, then the 60th enters PLAY.
    task automatic serve_to_play();
        frames(SERVE_N - 1);
        bus.pause = 1'b0;
        expq.push_back(mk(S_PLAY, 1'b1, 1'b0, 1'b0, 1'b0));
        frames(1);
    endtask

    // One goal from PLAY, through POINT, to PLAY again (or GAMEOVER).
    task automatic play_point(input bit right_side, input bit hold_pause);
        if (right_side) begin
            exp_r++;
            exp_dir  = 1'b0;
            bus.posx = 10'd5;
        end else begin
            exp_l++;
            exp_dir  = 1'b1;
            bus.posx = 10'd700;
        end
        expq.push_back(mk(S_POINT, 1'b0, 1'b0, 1'b0, 1'b0));
        frames(1);
        bus.posx  = 10'd320;
        bus.pause = hold_pause;
        frames(POINT_N - 1);
        if (exp_l == 9 || exp_r == 9) begin
            expq.push_back(mk(S_GAMEOVER, 1'b0, 1'b0, 1'b1, exp_r == 9));
            frames(1);
        end else begin
            push_serve_entry();
            frames(1);
            serve_to_play();
        end
    endtask

    task automatic press_start(input string name);
        bus.start = 1'b1;
        wait_state(S_SERVE, 3, name);
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // NOTE: the bench drives inputs with blocking assignments, always one
        // time unit after the rising edge, so the DUT never races them.
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.posx       = 10'd320;
        exp_l = 0; exp_r = 0; exp_dir = 1'b1;
        expq.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        cycles(3);
        reset = 1'b0;
        cycles(3);

        // 1: start -> SERVE with one ball_reset pulse, 60 ticks -> PLAY.
        push_serve_entry();
        press_start("start_to_serve");
        serve_to_play();

        // 2: left-player point, back through SERVE to PLAY.
        play_point(1'b0, 1'b0);

        // 3: posx in the right goal between ticks only: nothing happens.
        bus.posx = 10'd5;
        cycles(3);
        bus.posx = 10'd320;
        cycles(1);
        play_point(1'b1, 1'b0);

        // 4: pause stops the ball and the goal check; POINT/SERVE keep counting.
        expq.push_back(mk(S_PLAY, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.pause = 1'b1;
        cycles(2);
        bus.posx = 10'd700;
        frames(1);
        bus.posx = 10'd320;
        expq.push_back(mk(S_PLAY, 1'b1, 1'b0, 1'b0, 1'b0));
        bus.pause = 1'b0;
        cycles(2);
        play_point(1'b0, 1'b1);

        // 5: right player to 9 -> GAMEOVER, scores held, restart.
        for (int i = 0; i < 8; i++) play_point(1'b1, 1'b0);
        bus.posx = 10'd5;
        frames(3);
        bus.posx = 10'd320;
        exp_l = 0; exp_r = 0; exp_dir = 1'b1;
        push_serve_entry();
        press_start("restart_from_gameover");
        serve_to_play();

        // 6: reset mid-PLAY with score_l=4, start held through release.
        for (int i = 0; i < 4; i++) play_point(1'b0, 1'b0);
        check("score_l_before_reset", bus.score_l, 4);
        #1;
        exp_l = 0; exp_r = 0; exp_dir = 1'b1;
        expq.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        reset     = 1'b1;
        bus.start = 1'b1;
        #1;
        check("async_reset_state", bus.game_state, S_IDLE);
        check("async_reset_score_l", bus.score_l, 0);
        check("async_reset_ball_run", bus.ball_run, 0);
        check("async_reset_serve_dir", bus.serve_dir, 1);
        cycles(3);
        reset = 1'b0;
        cycles(12);
        check("held_start_ignored", bus.game_state, S_IDLE);
        bus.start = 1'b0;
        cycles(4);
        push_serve_entry();
        press_start("repress_after_reset");
        cycles(6);

        check("expectations_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow sequencer for the VGA pong design.
- Samples the ball position once per frame and decides when the ball may move, when it is re-centred and which side serves.
- Keeps both players' scores and declares a winner.
- Sits beside the position, paddle and image blocks; its score and state outputs feed the image block for display.

Parameters:
- GOAL_L, 10'd8: ball posx at or below this value is a right-player point.
- GOAL_R, 10'd624: ball posx at or above this value is a left-player point. GOAL_L < GOAL_R is required.
- MAX_SCORE, 4'd9: score value that ends the game (range 1..15).
- SERVE_FRAMES, 8'd60: frames held in SERVE before play starts.
- POINT_FRAMES, 8'd30: frames held in POINT after a goal.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- frame_tick, input, 1: one-cycle pulse at the start of each frame (vsync period).
- start, input, 1: raw push button, asynchronous to clk.
- pause, input, 1: level; freezes play while high.
- posx, input, 10: current ball x position.
- ball_run, output, 1: enables ball motion in the position block.
- ball_reset, output, 1: one-cycle pulse; position block re-centres the ball.
- serve_dir, output, 1: 0 = serve toward left, 1 = serve toward right.
- score_l, output, 4: left player score.
- score_r, output, 4: right player score.
- game_state, output, 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- winner_valid, output, 1: high only in GAMEOVER.
- winner, output, 1: 0 = left won, 1 = right won; meaningful only while winner_valid = 1.

Behaviour:

Reset values:
- game_state=IDLE, score_l=0, score_r=0, ball_run=0, ball_reset=0, serve_dir=1, winner_valid=0, winner=0.
- Frame counter = 0; start synchroniser flops = 0.

Start input:
- start passes through a 2-flop synchroniser, then a rising-edge detector.
- start_evt is high for one cycle; it is active 2-3 clk after the button edge.
- A button held high produces one event only.

Frame counter:
- 8 bits; loaded to 0 on every state entry.
- Increments on frame_tick only.

State transitions:
- IDLE: on start_evt, clear scores, serve_dir=1, go to SERVE.
- SERVE:
  - ball_reset pulses exactly in the first cycle after entry.
  - When frame_tick arrives with counter == SERVE_FRAMES-1, go to PLAY.
- PLAY:
  - ball_run=1 while pause=0. ball_run drops in the same cycle pause is seen high (registered: 1 clk after pause).
  - Goal check runs only on a frame_tick cycle with pause=0.
  - posx <= GOAL_L: score_r += 1, serve_dir=0, go to POINT.
  - posx >= GOAL_R: score_l += 1, serve_dir=1, go to POINT.
  - The two conditions are mutually exclusive by the parameter constraint.
  - Score update and state change occur on the same clock edge.
  - posx between frame ticks is ignored.
- POINT:
  - ball_run=0.
  - After POINT_FRAMES frame_ticks: if score_l == MAX_SCORE or score_r == MAX_SCORE, go to GAMEOVER; otherwise go to SERVE.
  - In GAMEOVER, winner = (score_r == MAX_SCORE).
- GAMEOVER:
  - winner_valid=1, ball_run=0; scores held for display.
  - On start_evt: clear scores, winner_valid=0, serve_dir=1, go to SERVE.

Start and pause outside their defined use:
- start_evt is ignored in SERVE, PLAY and POINT.
- pause affects only PLAY. The SERVE and POINT counters keep running while pause is high.

Scores:
- Score registers saturate at MAX_SCORE and never wrap.
- Only one score changes per goal.

Boundary and mid-operation cases:
- frame_tick coincident with state entry: the counter is loaded to 0 on entry and the tick is not counted.
- Reset asserted mid-game: immediate return to reset values; a pending ball_reset pulse is dropped.
- A start press during reset release is lost, because the synchroniser is cleared.

Test Plan:
1. Reset, then start pulse 3 clk wide -> state IDLE→SERVE within 3 clk; ball_reset exactly one cycle; after 60 frame_ticks state=PLAY, ball_run=1, serve_dir=1.
2. PLAY, posx=700 (above GOAL_R) at a frame_tick -> score_l 0→1, serve_dir=1, state=POINT; after 30 ticks state=SERVE with a new ball_reset pulse.
3. PLAY, posx=5 at a frame_tick -> score_r=1, serve_dir=0. posx=5 held between ticks only -> no score change.
4. pause=1 in PLAY with posx=700 at a tick -> no score change, ball_run=0. pause=0 at the next tick -> score_l increments.
5. score_r=8, right goal -> score_r=9, POINT, then GAMEOVER with winner_valid=1, winner=1. Further ticks at posx=5 -> score stays 9. start -> scores 0, SERVE.
6. reset asserted mid-PLAY with score_l=4 -> all outputs at reset values asynchronously, before the next clk edge; start held high through reset release produces no SERVE until released and re-pressed.
